// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX/MEM hazard scoreboard.
package hazard_pkg;

  // EX operand mux selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // MEM-stage ALU result
  localparam logic [1:0] FWD_WB  = 2'b10;  // WB-stage write data

  localparam int REG_W = 5;

  // One in-flight instruction as seen by the scoreboard.
  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             is_load;
    logic [REG_W-1:0] rd;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // True when the slot will write the register the consumer actually reads.
  // x0 is hardwired to zero and never produces a dependency.
  function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] num,
                                    input logic used);
    return used & s.valid & s.regwrite & (s.rd != '0) & (s.rd == num);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand dependency resolver: picks the forward source for one ID source
// register and flags a load directly ahead of it.
module hazard_match
  import hazard_pkg::*;
(
  input  slot_t            slot_ex,
  input  slot_t            slot_mem,
  input  logic [REG_W-1:0] num,
  input  logic             used,
  output logic [1:0]       sel,
  output logic             load_hit
);

  logic ex_hit;
  logic mem_hit;

  // The MEM slot's load flag is irrelevant here: its data is already in WB
  // by the time the consumer reaches EX.
  logic unused_mem_load;
  assign unused_mem_load = slot_mem.is_load;

  assign ex_hit  = slot_hit(slot_ex, num, used);
  assign mem_hit = slot_hit(slot_mem, num, used);

  // Youngest producer wins; a load in EX cannot forward and becomes a stall.
  always_comb begin
    sel      = FWD_RF;
    load_hit = 1'b0;
    if (ex_hit && slot_ex.is_load) begin
      load_hit = 1'b1;
      if (mem_hit) sel = FWD_WB;
    end else if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destinations of the EX and MEM instructions, raises the load-use
// stall and registers the EX operand forwarding selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       R1_Num,
  input  logic [4:0]       R2_Num,
  input  logic             R1_Used,
  input  logic             R2_Used,
  input  logic             RegWrite_ID,
  input  logic             MemToReg_ID,
  input  logic [4:0]       WB_Num_ID,
  input  logic             Flush,
  output logic             Stall,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic [CNT_W-1:0] Stall_Count
);

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] sel_a, sel_b;
  logic       load_hit_a, load_hit_b;
  logic       stall_w;
  logic       bubble_w;

  hazard_match u_match_rs1 (
    .slot_ex  (ex_q),
    .slot_mem (mem_q),
    .num      (R1_Num),
    .used     (R1_Used),
    .sel      (sel_a),
    .load_hit (load_hit_a)
  );

  hazard_match u_match_rs2 (
    .slot_ex  (ex_q),
    .slot_mem (mem_q),
    .num      (R2_Num),
    .used     (R2_Used),
    .sel      (sel_b),
    .load_hit (load_hit_b)
  );

  // A squashed ID instruction never stalls; Flush dominates.
  assign stall_w  = (load_hit_a | load_hit_b) & ~Flush;
  assign bubble_w = stall_w | Flush;

  // Advance the two-slot pipeline image and compute next selects and count.
  always_comb begin
    mem_d   = ex_q;
    ex_d    = SLOT_BUBBLE;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    cnt_d   = cnt_q;
    if (!bubble_w) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = RegWrite_ID;
      ex_d.is_load  = MemToReg_ID;
      ex_d.rd       = WB_Num_ID;
      fwd_a_d       = sel_a;
      fwd_b_d       = sel_b;
    end
    if (stall_w) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset clears both slots, which also drops Stall at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= SLOT_BUBBLE;
      mem_q   <= SLOT_BUBBLE;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Stall       = stall_w;
  assign FwdA        = fwd_a_q;
  assign FwdB        = fwd_b_q;
  assign Stall_Count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios followed by
// random instruction streams, checked against a list-of-in-flight model.
module tb_hazard_scoreboard;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       R1_Num, R2_Num, WB_Num_ID;
  logic             R1_Used, R2_Used, RegWrite_ID, MemToReg_ID, Flush;
  logic             Stall;
  logic [1:0]       FwdA, FwdB;
  logic [CNT_W-1:0] Stall_Count;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .R1_Num      (R1_Num),
    .R2_Num      (R2_Num),
    .R1_Used     (R1_Used),
    .R2_Used     (R2_Used),
    .RegWrite_ID (RegWrite_ID),
    .MemToReg_ID (MemToReg_ID),
    .WB_Num_ID   (WB_Num_ID),
    .Flush       (Flush),
    .Stall       (Stall),
    .FwdA        (FwdA),
    .FwdB        (FwdB),
    .Stall_Count (Stall_Count)
  );

  always #5 clk = ~clk;

  // In-flight instructions, youngest first: index 0 is EX, index 1 is MEM.
  typedef struct {
    bit valid;
    bit wr;
    bit ld;
    int rd;
  } instr_t;

  instr_t inflight[$];
  int     exp_fwda, exp_fwdb, exp_cnt;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    instr_t b;
    b = '{valid: 0, wr: 0, ld: 0, rd: 0};
    inflight = {};
    inflight.push_back(b);
    inflight.push_back(b);
    exp_fwda = 0;
    exp_fwdb = 0;
    exp_cnt  = 0;
  endfunction

  // Distance to the youngest in-flight writer of num decides the source:
  // one ahead -> MEM result (or a stall if it is a load), two ahead -> WB data.
  function automatic void resolve(input int num, input bit used,
                                  output int sel, output bit load_hit);
    bit found;
    sel      = 0;
    load_hit = 0;
    found    = 0;
    if (used && num != 0) begin
      for (int i = 0; i < inflight.size(); i++) begin
        if (!found && inflight[i].valid && inflight[i].wr && inflight[i].rd == num) begin
          found = 1;
          if (i == 0 && inflight[i].ld) load_hit = 1;
          else if (i == 0)              sel = 1;
          else                          sel = 2;
        end
      end
    end
  endfunction

  // One ID instruction presented for one clock, with full checking.
  task automatic issue(input int r1, input bit u1, input int r2, input bit u2,
                       input bit wr, input bit ld, input int rd, input bit fl);
    int     sa, sb;
    bit     la, lb, stall_exp;
    instr_t n;
    @(negedge clk);
    R1_Num = 5'(r1); R1_Used = u1; R2_Num = 5'(r2); R2_Used = u2;
    RegWrite_ID = wr; MemToReg_ID = ld; WB_Num_ID = 5'(rd); Flush = fl;
    #1;
    resolve(r1, u1, sa, la);
    resolve(r2, u2, sb, lb);
    stall_exp = (la | lb) & ~fl;
    chk("stall", 32'(Stall), 32'(stall_exp));
    @(posedge clk);
    if (stall_exp || fl) begin
      n = '{valid: 0, wr: 0, ld: 0, rd: 0};
      exp_fwda = 0;
      exp_fwdb = 0;
    end else begin
      n = '{valid: 1, wr: wr, ld: ld, rd: rd};
      exp_fwda = sa;
      exp_fwdb = sb;
    end
    if (stall_exp) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    inflight.push_front(n);
    void'(inflight.pop_back());
    #1;
    chk("fwda", 32'(FwdA), 32'(exp_fwda));
    chk("fwdb", 32'(FwdB), 32'(exp_fwdb));
    chk("stall_count", 32'(Stall_Count), 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    R1_Num = '0; R2_Num = '0; R1_Used = 0; R2_Used = 0;
    RegWrite_ID = 0; MemToReg_ID = 0; WB_Num_ID = '0; Flush = 0;
    model_reset();
    #12;
    chk("reset_stall", 32'(Stall), 32'd0);
    chk("reset_fwda", 32'(FwdA), 32'd0);
    chk("reset_fwdb", 32'(FwdB), 32'd0);
    chk("reset_count", 32'(Stall_Count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x5 ; sub x6,x5,x7
    issue(0, 0, 0, 0, 1, 0, 5, 0);
    issue(5, 1, 7, 1, 1, 0, 6, 0);
    chk("alu_fwd_a", 32'(FwdA), 32'd1);
    chk("alu_fwd_b", 32'(FwdB), 32'd0);

    // lw x5 ; add x6,x5,x5 (stalled once, then re-presented)
    issue(0, 0, 0, 0, 1, 1, 5, 0);
    issue(5, 1, 5, 1, 1, 0, 6, 0);
    chk("lu_count", 32'(Stall_Count), 32'd1);
    issue(5, 1, 5, 1, 1, 0, 6, 0);
    chk("lu_fwd_a", 32'(FwdA), 32'd2);
    chk("lu_fwd_b", 32'(FwdB), 32'd2);

    // addi x0 ; add x6,x0,x0
    issue(0, 0, 0, 0, 1, 0, 0, 0);
    issue(0, 1, 0, 1, 1, 0, 6, 0);
    chk("x0_fwd_a", 32'(FwdA), 32'd0);

    // add x5 ; add x5 ; add x6,x5,x0
    issue(0, 0, 0, 0, 1, 0, 5, 0);
    issue(0, 0, 0, 0, 1, 0, 5, 0);
    issue(5, 1, 0, 1, 1, 0, 6, 0);
    chk("young_fwd_a", 32'(FwdA), 32'd1);

    // lw x5 then flushed dependent
    issue(0, 0, 0, 0, 1, 1, 5, 0);
    issue(5, 1, 5, 1, 1, 0, 6, 1);
    chk("flush_fwd_a", 32'(FwdA), 32'd0);
    chk("flush_count", 32'(Stall_Count), 32'd1);

    // Reset during a load-use stall
    issue(0, 0, 0, 0, 1, 1, 5, 0);
    @(negedge clk);
    R1_Num = 5'd5; R1_Used = 1; R2_Num = 5'd5; R2_Used = 1;
    RegWrite_ID = 1; MemToReg_ID = 0; WB_Num_ID = 5'd6; Flush = 0;
    #1;
    chk("pre_rst_stall", 32'(Stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_fwda", 32'(FwdA), 32'd0);
    chk("rst_fwdb", 32'(FwdB), 32'd0);
    chk("rst_count", 32'(Stall_Count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 0, 0, 0, 1, 0, 5, 0);
    issue(5, 1, 5, 1, 1, 0, 6, 0);
    chk("post_rst_fwd_a", 32'(FwdA), 32'd1);

    // Random instruction stream over a small register window.
    for (int i = 0; i < 3000; i++) begin
      issue($urandom_range(0, 7), 1'($urandom % 2), $urandom_range(0, 7), 1'($urandom % 2),
            1'(($urandom % 8) != 0), 1'(($urandom % 3) == 0), $urandom_range(0, 7),
            1'(($urandom % 10) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
